// File: rtl/juego_pkg.sv
// juego_pkg: shared screen geometry, FSM encodings and refresh-tick position for Falling Cubes.
package juego_pkg;
  localparam int MAX_X = 640;
  localparam int MAX_Y = 480;
  localparam int TAMANIO_CANASTA = 90;
  localparam int TAMANIO_CUBO = 16;
  localparam logic [9:0] FILA_REFRESCO = 10'd481;
  localparam logic [9:0] COLUMNA_REFRESCO = 10'd0;
  localparam logic [9:0] SEMILLA = 10'h2A5;
  localparam logic [2:0] E_ESPERA = 3'd0;
  localparam logic [2:0] E_SOLTAR = 3'd1;
  localparam logic [2:0] E_CAYENDO = 3'd2;
  localparam logic [2:0] E_PAUSA = 3'd3;
  localparam logic [2:0] E_FIN = 3'd4;
  // Folds an out-of-range LFSR value back onto the screen by dropping its top bit.
  function automatic logic [9:0] columna(input logic [9:0] v, input logic [9:0] limite);
    return v > limite ? v - 10'd512 : v;
  endfunction
endpackage

// File: rtl/generador_aleatorio.sv
// generador_aleatorio: 10-bit Fibonacci LFSR (x^10+x^7+1) advancing every cycle.
module generador_aleatorio (
  input  logic       clk,
  input  logic       reset,
  output logic [9:0] o_valor
);
  import juego_pkg::*;
  logic [9:0] r_lfsr;
  always_ff @(posedge clk)
    r_lfsr <= reset ? SEMILLA : {r_lfsr[8:0], r_lfsr[9] ^ r_lfsr[6]};
  assign o_valor = r_lfsr;
endmodule

// File: rtl/control_juego.sv
// control_juego: Falling Cubes sequencer; drops cubes, judges catch/miss per frame, keeps score, lives and level.
module control_juego #(
  parameter int MAX_X = juego_pkg::MAX_X,
  parameter int MAX_Y = juego_pkg::MAX_Y,
  parameter int TAMANIO_CANASTA = juego_pkg::TAMANIO_CANASTA,
  parameter int TAMANIO_CUBO = juego_pkg::TAMANIO_CUBO,
  parameter int VIDAS_INICIALES = 3,
  parameter int ATRAPADOS_POR_NIVEL = 10,
  parameter int PAUSA_FRAMES = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] pixel_x,
  input  logic [9:0] pixel_y,
  input  logic       boton_inicio,
  input  logic [9:0] pos_x_canasta,
  input  logic [8:0] pos_y_canasta,
  input  logic [9:0] pos_x_cubo,
  input  logic [9:0] pos_y_cubo,
  output logic       reset_canasta,
  output logic       soltar_cubo,
  output logic       cubo_activo,
  output logic [9:0] x_cubo_inicial,
  output logic [7:0] puntaje,
  output logic [1:0] vidas,
  output logic [1:0] nivel,
  output logic       fin_juego
);
  import juego_pkg::*;
  localparam int WP = $clog2(PAUSA_FRAMES + 1);
  localparam int WN = $clog2(ATRAPADOS_POR_NIVEL + 1);
  logic [2:0] r_estado, w_siguiente;
  logic r_boton_q;
  logic [WP-1:0] r_pausa;
  logic [WN-1:0] r_cuenta_nivel;
  logic [7:0] r_puntaje;
  logic [1:0] r_vidas, r_nivel;
  logic [9:0] r_x_inicial, w_lfsr;
  logic [10:0] w_cubo_y_inf, w_cubo_x_der, w_canasta_x_der;
  logic w_refrescar, w_inicio, w_arranque, w_juzgar, w_fin_pausa;
  logic w_abajo, w_solapa, w_atrapado, w_fallo;

  generador_aleatorio u_generador (
    .clk(clk),
    .reset(reset),
    .o_valor(w_lfsr)
  );

  assign w_refrescar = pixel_y == FILA_REFRESCO && pixel_x == COLUMNA_REFRESCO;
  assign w_inicio = boton_inicio && !r_boton_q;
  assign w_arranque = w_inicio && (r_estado == E_ESPERA || r_estado == E_FIN);
  assign w_juzgar = r_estado == E_CAYENDO && w_refrescar;
  assign w_fin_pausa = w_refrescar && r_pausa == WP'(PAUSA_FRAMES - 1);

  // 11-bit sums so edges near the screen limits never wrap.
  assign w_cubo_y_inf = {1'b0, pos_y_cubo} + 11'(TAMANIO_CUBO);
  assign w_cubo_x_der = {1'b0, pos_x_cubo} + 11'(TAMANIO_CUBO);
  assign w_canasta_x_der = {1'b0, pos_x_canasta} + 11'(TAMANIO_CANASTA);
  assign w_abajo = w_cubo_y_inf >= {2'b00, pos_y_canasta};
  assign w_solapa = w_cubo_x_der > {1'b0, pos_x_canasta} && {1'b0, pos_x_cubo} <= w_canasta_x_der;
  assign w_atrapado = w_abajo && w_solapa;
  assign w_fallo = w_cubo_y_inf >= 11'(MAX_Y) && !w_atrapado;

  always_comb begin
    w_siguiente = E_ESPERA;
    case (r_estado)
      E_ESPERA, E_FIN: w_siguiente = w_arranque ? E_SOLTAR : r_estado;
      E_SOLTAR: w_siguiente = E_CAYENDO;
      E_CAYENDO: w_siguiente = !w_juzgar ? E_CAYENDO :
                               w_atrapado ? E_PAUSA :
                               !w_fallo ? E_CAYENDO :
                               r_vidas == 2'd1 ? E_FIN : E_PAUSA;
      E_PAUSA: w_siguiente = w_fin_pausa ? E_SOLTAR : E_PAUSA;
      default: w_siguiente = E_ESPERA;
    endcase
  end

  always_ff @(posedge clk)
    if (reset) begin
      r_estado <= E_ESPERA;
      r_boton_q <= 1'b1;
      r_pausa <= '0;
      r_cuenta_nivel <= '0;
      r_puntaje <= '0;
      r_vidas <= '0;
      r_nivel <= '0;
      r_x_inicial <= '0;
    end else begin
      r_estado <= w_siguiente;
      r_boton_q <= boton_inicio;
      r_pausa <= (r_estado != E_PAUSA || w_fin_pausa) ? '0 : r_pausa + WP'(w_refrescar);
      if (w_siguiente == E_SOLTAR)
        r_x_inicial <= columna(w_lfsr, 10'(MAX_X - TAMANIO_CUBO - 1));
      if (w_arranque) begin
        r_puntaje <= '0;
        r_vidas <= 2'(VIDAS_INICIALES);
        r_nivel <= '0;
        r_cuenta_nivel <= '0;
      end else if (w_juzgar && w_atrapado) begin
        r_puntaje <= r_puntaje + 8'(r_puntaje != 8'hFF);
        if (r_cuenta_nivel == WN'(ATRAPADOS_POR_NIVEL - 1)) begin
          r_cuenta_nivel <= '0;
          r_nivel <= r_nivel + 2'(r_nivel != 2'd3);
        end else
          r_cuenta_nivel <= r_cuenta_nivel + 1'b1;
      end else if (w_juzgar && w_fallo)
        r_vidas <= r_vidas - 2'd1;
    end

  assign reset_canasta = r_estado == E_ESPERA;
  assign soltar_cubo = r_estado == E_SOLTAR;
  assign cubo_activo = r_estado == E_CAYENDO;
  assign fin_juego = r_estado == E_FIN;
  assign x_cubo_inicial = r_x_inicial;
  assign puntaje = r_puntaje;
  assign vidas = r_vidas;
  assign nivel = r_nivel;
endmodule
